// File: rtl/z_event_counter.sv
// Two-digit BCD counter of z rising edges with active-low 7-segment decode.
// Define Z_EVENT_COUNTER_SATURATE_EN to hold at 99 instead of wrapping to 00.
module z_event_counter (
   input  logic       clk,
   input  logic       reset,
   input  logic       z,
   input  logic       clear,
   input  logic       hold,
   output logic [3:0] count_ones,
   output logic [3:0] count_tens,
   output logic [6:0] hex0,
   output logic [6:0] hex1,
   output logic       event_pulse,
   output logic       wrap
);

   typedef enum logic {
      WAIT_HIGH = 1'b0,
      WAIT_LOW  = 1'b1
   } state_t;

   state_t state;
   state_t next_state;
   logic   z_q;
   logic   rise;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= WAIT_HIGH;
         z_q   <= 1'b0;
      end else begin
         state <= next_state;
         z_q   <= z;
      end
   end

   // z_q always mirrors the state, so a rise is z high while the last sample was low
   always_comb begin
      next_state = state;
      rise       = 1'b0;
      case (state)
         WAIT_HIGH: begin
            if (z) begin
               next_state = WAIT_LOW;
               rise       = ~z_q;
            end
         end
         WAIT_LOW: begin
            if (!z) begin
               next_state = WAIT_HIGH;
            end
         end
      endcase
   end

`ifdef Z_EVENT_COUNTER_SATURATE_EN
   assign wrap = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_ones  <= 4'd0;
         count_tens  <= 4'd0;
         event_pulse <= 1'b0;
`ifndef Z_EVENT_COUNTER_SATURATE_EN
         wrap        <= 1'b0;
`endif
      end else begin
         event_pulse <= 1'b0;
`ifndef Z_EVENT_COUNTER_SATURATE_EN
         wrap        <= 1'b0;
`endif
         if (clear) begin
            count_ones <= 4'd0;
            count_tens <= 4'd0;
         end else if (!hold && rise) begin
            event_pulse <= 1'b1;
            if (count_ones != 4'd9) begin
               count_ones <= count_ones + 4'd1;
            end else if (count_tens != 4'd9) begin
               count_ones <= 4'd0;
               count_tens <= count_tens + 4'd1;
            end else begin
`ifndef Z_EVENT_COUNTER_SATURATE_EN
               count_ones <= 4'd0;
               count_tens <= 4'd0;
               wrap       <= 1'b1;
`endif
            end
         end
      end
   end

   // Segment order is {g,f,e,d,c,b,a}, active low; non-BCD codes blank the digit
   function automatic logic [6:0] seg7(input logic [3:0] digit);
      case (digit)
         4'd0:    seg7 = 7'b1000000;
         4'd1:    seg7 = 7'b1111001;
         4'd2:    seg7 = 7'b0100100;
         4'd3:    seg7 = 7'b0110000;
         4'd4:    seg7 = 7'b0011001;
         4'd5:    seg7 = 7'b0010010;
         4'd6:    seg7 = 7'b0000010;
         4'd7:    seg7 = 7'b1111000;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0010000;
         default: seg7 = 7'b1111111;
      endcase
   endfunction

   assign hex0 = seg7(count_ones);
   assign hex1 = seg7(count_tens);

endmodule

// File: tb/tb_z_event_counter.sv
// Randomized bench for z_event_counter: an integer-count model is compared
// against the DUT on every falling clock edge, plus directed literal checks.
module tb_z_event_counter;

   logic       clk = 1'b0;
   logic       reset;
   logic       z;
   logic       clear;
   logic       hold;
   logic [3:0] count_ones;
   logic [3:0] count_tens;
   logic [6:0] hex0;
   logic [6:0] hex1;
   logic       event_pulse;
   logic       wrap;

   int checks = 0;
   int fails = 0;
   int pulse_seen = 0;
   bit check_en = 1'b0;

   int m_count;
   bit m_prev_z;
   bit m_rise;
   bit m_pulse;
   bit m_wrap;

   z_event_counter dut (
      .clk(clk),
      .reset(reset),
      .z(z),
      .clear(clear),
      .hold(hold),
      .count_ones(count_ones),
      .count_tens(count_tens),
      .hex0(hex0),
      .hex1(hex1),
      .event_pulse(event_pulse),
      .wrap(wrap)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] seg(input int d);
      case (d)
         0:       return 7'b1000000;
         1:       return 7'b1111001;
         2:       return 7'b0100100;
         3:       return 7'b0110000;
         4:       return 7'b0011001;
         5:       return 7'b0010010;
         6:       return 7'b0000010;
         7:       return 7'b1111000;
         8:       return 7'b0000000;
         9:       return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Model: count the 0->1 transitions of z as sampled at each clock edge
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_count  = 0;
         m_prev_z = 1'b0;
         m_pulse  = 1'b0;
         m_wrap   = 1'b0;
      end else begin
         m_rise   = z && !m_prev_z;
         m_prev_z = z;
         m_pulse  = 1'b0;
         m_wrap   = 1'b0;
         if (clear) begin
            m_count = 0;
         end else if (!hold && m_rise) begin
            m_pulse = 1'b1;
            if (m_count == 99) begin
`ifdef Z_EVENT_COUNTER_SATURATE_EN
               m_count = 99;
`else
               m_count = 0;
               m_wrap  = 1'b1;
`endif
            end else begin
               m_count = m_count + 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         check_output("count_ones", count_ones, m_count % 10);
         check_output("count_tens", count_tens, m_count / 10);
         check_output("hex0", hex0, seg(m_count % 10));
         check_output("hex1", hex1, seg(m_count / 10));
         check_output("event_pulse", event_pulse, m_pulse);
         check_output("wrap", wrap, m_wrap);
         if (event_pulse === 1'b1) pulse_seen++;
      end
   end

   // Drive one cycle of inputs and return just after the following falling edge
   task automatic apply_stimulus(input bit zv, input bit cv, input bit hv);
      z     = zv;
      clear = cv;
      hold  = hv;
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic pulse_z(input int n);
      for (int i = 0; i < n; i++) begin
         apply_stimulus(1'b1, 1'b0, 1'b0);
         apply_stimulus(1'b0, 1'b0, 1'b0);
      end
   endtask

   initial begin
      reset = 1'b1;
      z     = 1'b0;
      clear = 1'b0;
      hold  = 1'b0;
      #1 reset = 1'b0;
      #2;
      check_en = 1'b1;
      check_output("reset_hex0", hex0, 7'b1000000);
      check_output("reset_hex1", hex1, 7'b1000000);
      check_output("reset_ones", count_ones, 4'd0);
      check_output("reset_pulse", event_pulse, 1'b0);
      check_output("reset_wrap", wrap, 1'b0);
      @(negedge clk);
      #1 reset = 1'b1;

      pulse_z(3);
      check_output("three_ones", count_ones, 4'd3);
      check_output("three_tens", count_tens, 4'd0);
      check_output("three_hex0", hex0, 7'b0110000);

      pulse_seen = 0;
      repeat (10) apply_stimulus(1'b1, 1'b0, 1'b0);
      apply_stimulus(1'b0, 1'b0, 1'b0);
      check_output("held_high_ones", count_ones, 4'd4);
      check_output("held_high_pulses", pulse_seen, 1);

      apply_stimulus(1'b0, 1'b1, 1'b0);
      apply_stimulus(1'b1, 1'b0, 1'b1);
      check_output("hold_ones", count_ones, 4'd0);
      check_output("hold_pulse", event_pulse, 1'b0);
      apply_stimulus(1'b1, 1'b0, 1'b0);
      check_output("hold_release_ones", count_ones, 4'd0);
      apply_stimulus(1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b1, 1'b0, 1'b0);
      check_output("fresh_rise_ones", count_ones, 4'd1);
      apply_stimulus(1'b0, 1'b0, 1'b0);

      pulse_z(1);
      apply_stimulus(1'b1, 1'b1, 1'b0);
      check_output("clear_rise_ones", count_ones, 4'd0);
      check_output("clear_rise_pulse", event_pulse, 1'b0);
      apply_stimulus(1'b0, 1'b0, 1'b0);

      // Asynchronous reset landing between edges, right after a counted rise
      pulse_z(2);
      z = 1'b1;
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check_output("async_ones", count_ones, 4'd0);
      check_output("async_pulse", event_pulse, 1'b0);
      check_output("async_hex0", hex0, 7'b1000000);
      @(negedge clk);
      #1;
      z     = 1'b0;
      reset = 1'b1;
      apply_stimulus(1'b0, 1'b0, 1'b0);
      check_output("post_reset_pulse", event_pulse, 1'b0);
      check_output("post_reset_ones", count_ones, 4'd0);

      reset = 1'b0;
      z     = 1'b1;
      #1 reset = 1'b1;
      apply_stimulus(1'b1, 1'b0, 1'b0);
      check_output("first_edge_ones", count_ones, 4'd1);
      check_output("first_edge_pulse", event_pulse, 1'b1);
      apply_stimulus(1'b0, 1'b0, 1'b0);

      apply_stimulus(1'b0, 1'b1, 1'b0);
      pulse_z(98);
      check_output("preload_tens", count_tens, 4'd9);
      check_output("preload_ones", count_ones, 4'd8);
      apply_stimulus(1'b1, 1'b0, 1'b0);
      check_output("at99_ones", count_ones, 4'd9);
      check_output("at99_tens", count_tens, 4'd9);
      apply_stimulus(1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b1, 1'b0, 1'b0);
      check_output("rollover_pulse", event_pulse, 1'b1);
`ifdef Z_EVENT_COUNTER_SATURATE_EN
      check_output("sat_ones", count_ones, 4'd9);
      check_output("sat_tens", count_tens, 4'd9);
      check_output("sat_wrap", wrap, 1'b0);
`else
      check_output("wrap_ones", count_ones, 4'd0);
      check_output("wrap_tens", count_tens, 4'd0);
      check_output("wrap_strobe", wrap, 1'b1);
`endif
      apply_stimulus(1'b0, 1'b0, 1'b0);
      check_output("wrap_one_cycle", wrap, 1'b0);

      for (int i = 0; i < 400; i++) begin
         apply_stimulus(1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 31) == 0),
                        1'($urandom_range(0, 7) == 0));
      end

      check_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/z_event_counter.md
Z_EVENT_COUNTER -- requirements
Module: z_event_counter

Interface
REQ-001 The block SHALL have no parameters; all behaviour SHALL be fixed except the single macro in Configuration.
REQ-002 clk  input  1  single clock; all state SHALL update on posedge clk only.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 SHALL force the reset state immediately, regardless of clk.
REQ-004 z  input  1  detection flag from the upstream Moore sequence detector, synchronous to clk.
REQ-005 clear  input  1  synchronous, active-high; zeroes the count.
REQ-006 hold  input  1  synchronous, active-high; freezes the count.
REQ-007 count_ones  output  4  BCD units digit, registered.
REQ-008 count_tens  output  4  BCD tens digit, registered.
REQ-009 hex0  output  7  active-low 7-segment pattern {g,f,e,d,c,b,a} for count_ones.
REQ-010 hex1  output  7  active-low 7-segment pattern for count_tens.
REQ-011 event_pulse  output  1  registered, one-cycle strobe per counted event.
REQ-012 wrap  output  1  registered, one-cycle strobe on 99->00 rollover.

Function
REQ-013 z SHALL be registered into z_q every cycle, including when hold=1 or clear=1.
REQ-014 Edge tracking SHALL use a 2-state FSM: WAIT_HIGH (z_q=0 seen) and WAIT_LOW (z_q=1 seen).
REQ-015 In WAIT_HIGH with z=1, the FSM SHALL go to WAIT_LOW and flag a rise; otherwise it SHALL stay in WAIT_HIGH.
REQ-016 In WAIT_LOW with z=0, the FSM SHALL go to WAIT_HIGH; otherwise it SHALL stay in WAIT_LOW. z held high SHALL count exactly once.
REQ-017 A rise SHALL increment the count at the same clk edge that moves the FSM to WAIT_LOW; latency z->count SHALL be 1 clk.
REQ-018 event_pulse SHALL be 1 in the cycle after a counted rise, coincident with the new count value, and 0 otherwise.
REQ-019 Increment: ones<9 -> ones+1; ones=9 -> ones=0 and tens+1; at 99 -> 00 with wrap=1 for one cycle.
REQ-020 Priority SHALL be clear > hold > increment.
REQ-021 clear=1: count SHALL become 00; event_pulse=0 and wrap=0 next cycle, even if a rise coincides; FSM SHALL still track z.
REQ-022 hold=1 (clear=0): count SHALL be unchanged; a coincident rise SHALL be dropped, with event_pulse=0 and FSM still advancing.
REQ-023 hex0/hex1 SHALL be a combinational decode of the registered digits: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-024 Digit codes 10-15 SHALL never occur; the decoder SHALL map them to 1111111 (blank).

Reset
REQ-025 reset=0 SHALL immediately set count_ones=0, count_tens=0, z_q=0, FSM=WAIT_HIGH, event_pulse=0, wrap=0, hex0=hex1=1000000.
REQ-026 If z=1 on the first clk edge after reset release, that SHALL count as a rise.
REQ-027 Reset asserted mid-count SHALL discard any in-flight rise; no pulse SHALL appear after release.

Configuration
REQ-028 Macro Z_EVENT_COUNTER_SATURATE_EN defined: the count SHALL stick at 99 on further rises, event_pulse SHALL still assert per rise, and wrap SHALL be constant 0.
REQ-029 Macro undefined: wrap-around behaviour SHALL be per REQ-019.

Verification
REQ-030 Reset, then three separate 1-cycle z pulses -> count 03, hex0=0110000, three event_pulse strobes each 1 cycle after its rise.
REQ-031 z held high for 10 cycles, then low -> count increments by exactly 1; exactly one event_pulse.
REQ-032 Preload to 98 via 98 pulses, then 2 more pulses -> 99, then 00 with wrap=1 for one cycle (macro undefined); with macro defined -> stays 99, wrap=0.
REQ-033 hold=1 during a rise -> count unchanged, no event_pulse; hold released while z is still high -> no count; next fresh rise -> +1.
REQ-034 clear and a rise in the same cycle -> count 00, event_pulse=0; reset asserted asynchronously mid-clock -> outputs reach reset values before the next edge.
